// File: rtl/axi_lite_reg_slave.sv
// AXI4-Lite register bank with one outstanding transaction, byte strobes,
// read-only status words and per-register read/write access pulses.
module axi_lite_reg_slave #(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int REG_NUM = 16,
  parameter logic [REG_NUM-1:0] RO_MASK = {REG_NUM{1'b0}}
) (
  input  logic                              i_clk,
  input  logic                              i_rstn,
  input  logic [AXI_ADDR_WIDTH-1:0]         s_axi_araddr,
  input  logic                              s_axi_arvalid,
  output logic                              s_axi_arready,
  output logic [AXI_DATA_WIDTH-1:0]         s_axi_rdata,
  output logic [1:0]                        s_axi_rresp,
  output logic                              s_axi_rvalid,
  input  logic                              s_axi_rready,
  input  logic [AXI_ADDR_WIDTH-1:0]         s_axi_awaddr,
  input  logic                              s_axi_awvalid,
  output logic                              s_axi_awready,
  input  logic [AXI_DATA_WIDTH-1:0]         s_axi_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0]       s_axi_wstrb,
  input  logic                              s_axi_wvalid,
  output logic                              s_axi_wready,
  output logic [1:0]                        s_axi_bresp,
  output logic                              s_axi_bvalid,
  input  logic                              s_axi_bready,
  output logic [REG_NUM*AXI_DATA_WIDTH-1:0] o_reg_q,
  input  logic [REG_NUM*AXI_DATA_WIDTH-1:0] i_ro_val,
  output logic [REG_NUM-1:0]                o_wr_pulse,
  output logic [REG_NUM-1:0]                o_rd_pulse
);

  localparam int IDX_W  = $clog2(REG_NUM);
  localparam int STRB_W = AXI_DATA_WIDTH / 8;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {IDLE, WR_ACC, WR_RESP, RD_RESP} state_t;

  state_t state, state_d;

  logic [AXI_DATA_WIDTH-1:0] reg_q   [REG_NUM];
  logic [AXI_DATA_WIDTH-1:0] ro_word [REG_NUM];

  logic                      aw_got, w_got;
  logic [IDX_W-1:0]          aw_idx_q;
  logic                      aw_in_q;
  logic [AXI_DATA_WIDTH-1:0] wdata_q;
  logic [STRB_W-1:0]         wstrb_q;

  logic [IDX_W-1:0]          ar_idx, aw_idx, wr_idx;
  logic                      ar_in, aw_in, wr_in;
  logic [AXI_DATA_WIDTH-1:0] rd_word, wr_data;
  logic [STRB_W-1:0]         wr_strb;
  logic                      aw_fire, w_fire, commit;
  logic                      unused_addr_bits;

  for (genvar i = 0; i < REG_NUM; i++) begin : g_words
    assign o_reg_q[AXI_DATA_WIDTH*i +: AXI_DATA_WIDTH] = reg_q[i];
    assign ro_word[i] = i_ro_val[AXI_DATA_WIDTH*i +: AXI_DATA_WIDTH];
  end

  assign ar_idx  = s_axi_araddr[2 +: IDX_W];
  assign ar_in   = (s_axi_araddr[AXI_ADDR_WIDTH-1:IDX_W+2] == '0);
  assign rd_word = RO_MASK[ar_idx] ? ro_word[ar_idx] : reg_q[ar_idx];
  assign aw_idx  = s_axi_awaddr[2 +: IDX_W];
  assign aw_in   = (s_axi_awaddr[AXI_ADDR_WIDTH-1:IDX_W+2] == '0);
  assign unused_addr_bits = ^{s_axi_araddr[1:0], s_axi_awaddr[1:0]};

  // A beat arriving this cycle is merged with any already-held half so the
  // commit happens on the same edge as the second handshake.
  assign aw_fire = (state == WR_ACC) && !aw_got && s_axi_awvalid;
  assign w_fire  = (state == WR_ACC) && !w_got && s_axi_wvalid;
  assign commit  = (state == WR_ACC) && (aw_got || aw_fire) && (w_got || w_fire);
  assign wr_idx  = aw_got ? aw_idx_q : aw_idx;
  assign wr_in   = aw_got ? aw_in_q : aw_in;
  assign wr_data = w_got ? wdata_q : s_axi_wdata;
  assign wr_strb = w_got ? wstrb_q : s_axi_wstrb;

  always_ff @(posedge i_clk) begin
    if (!i_rstn) state <= IDLE;
    else         state <= state_d;
  end

  always_comb begin
    state_d       = state;
    s_axi_arready = 1'b0;
    s_axi_awready = 1'b0;
    s_axi_wready  = 1'b0;
    s_axi_rvalid  = 1'b0;
    s_axi_bvalid  = 1'b0;
    case (state)
      IDLE: begin
        s_axi_arready = 1'b1;
        if (s_axi_arvalid)                     state_d = RD_RESP;
        else if (s_axi_awvalid || s_axi_wvalid) state_d = WR_ACC;
      end
      WR_ACC: begin
        s_axi_awready = !aw_got;
        s_axi_wready  = !w_got;
        if (commit) state_d = WR_RESP;
      end
      WR_RESP: begin
        s_axi_bvalid = 1'b1;
        if (s_axi_bready) state_d = IDLE;
      end
      RD_RESP: begin
        s_axi_rvalid = 1'b1;
        if (s_axi_rready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      for (int i = 0; i < REG_NUM; i++) reg_q[i] <= '0;
      aw_got      <= 1'b0;
      w_got       <= 1'b0;
      aw_idx_q    <= '0;
      aw_in_q     <= 1'b0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      s_axi_rdata <= '0;
      s_axi_rresp <= RESP_OKAY;
      s_axi_bresp <= RESP_OKAY;
      o_wr_pulse  <= '0;
      o_rd_pulse  <= '0;
    end else begin
      o_wr_pulse <= '0;
      o_rd_pulse <= '0;
      if (state == IDLE && s_axi_arvalid) begin
        s_axi_rdata <= ar_in ? rd_word : '0;
        s_axi_rresp <= ar_in ? RESP_OKAY : RESP_DECERR;
        if (ar_in) o_rd_pulse[ar_idx] <= 1'b1;
      end
      if (aw_fire) begin
        aw_got   <= 1'b1;
        aw_idx_q <= aw_idx;
        aw_in_q  <= aw_in;
      end
      if (w_fire) begin
        w_got   <= 1'b1;
        wdata_q <= s_axi_wdata;
        wstrb_q <= s_axi_wstrb;
      end
      if (commit) begin
        if (!wr_in) begin
          s_axi_bresp <= RESP_DECERR;
        end else if (RO_MASK[wr_idx]) begin
          s_axi_bresp <= RESP_SLVERR;
        end else begin
          s_axi_bresp        <= RESP_OKAY;
          o_wr_pulse[wr_idx] <= 1'b1;
          for (int k = 0; k < STRB_W; k++)
            if (wr_strb[k]) reg_q[wr_idx][8*k +: 8] <= wr_data[8*k +: 8];
        end
      end
      if (state == WR_RESP && s_axi_bready) begin
        aw_got <= 1'b0;
        w_got  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// Directed bench for axi_lite_reg_slave: RW/RO/out-of-range accesses, strobes,
// channel skew, response back-pressure, read/write arbitration and mid-write reset.
module tb_axi_lite_reg_slave;

  logic         i_clk;
  logic         i_rstn;
  logic [31:0]  s_axi_araddr;
  logic         s_axi_arvalid;
  logic         s_axi_arready;
  logic [31:0]  s_axi_rdata;
  logic [1:0]   s_axi_rresp;
  logic         s_axi_rvalid;
  logic         s_axi_rready;
  logic [31:0]  s_axi_awaddr;
  logic         s_axi_awvalid;
  logic         s_axi_awready;
  logic [31:0]  s_axi_wdata;
  logic [3:0]   s_axi_wstrb;
  logic         s_axi_wvalid;
  logic         s_axi_wready;
  logic [1:0]   s_axi_bresp;
  logic         s_axi_bvalid;
  logic         s_axi_bready;
  logic [511:0] o_reg_q;
  logic [511:0] i_ro_val;
  logic [15:0]  o_wr_pulse;
  logic [15:0]  o_rd_pulse;

  int vectors = 0;
  int miscompares = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;

  logic [31:0] model [16];
  logic [31:0] rdata;
  logic [1:0]  resp;
  logic [15:0] pulse;
  logic        ok;
  int          cnt_before;
  int          held;

  axi_lite_reg_slave #(
    .AXI_DATA_WIDTH(32),
    .AXI_ADDR_WIDTH(32),
    .REG_NUM(16),
    .RO_MASK(16'h0004)
  ) dut (
    .i_clk(i_clk),
    .i_rstn(i_rstn),
    .s_axi_araddr(s_axi_araddr),
    .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata),
    .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid),
    .s_axi_rready(s_axi_rready),
    .s_axi_awaddr(s_axi_awaddr),
    .s_axi_awvalid(s_axi_awvalid),
    .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata),
    .s_axi_wstrb(s_axi_wstrb),
    .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp),
    .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready),
    .o_reg_q(o_reg_q),
    .i_ro_val(i_ro_val),
    .o_wr_pulse(o_wr_pulse),
    .o_rd_pulse(o_rd_pulse)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Pulse values seen at each edge are those of the cycle just ending.
  always @(posedge i_clk) begin
    wr_cnt <= wr_cnt + $countones(o_wr_pulse);
    rd_cnt <= rd_cnt + $countones(o_rd_pulse);
  end

  function automatic logic [511:0] packed_model();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[32*i +: 32] = model[i];
    return v;
  endfunction

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [511:0] observed,
                              input logic [511:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic do_read(input logic [31:0] addr, output logic [31:0] data,
                         output logic [1:0] rsp, output logic [15:0] pls, output logic done);
    int n = 0;
    s_axi_araddr  = addr;
    s_axi_arvalid = 1'b1;
    while (!s_axi_arready && n < 20) begin
      tick();
      n++;
    end
    tick();
    s_axi_arvalid = 1'b0;
    done = s_axi_rvalid && (n < 20);
    data = s_axi_rdata;
    rsp  = s_axi_rresp;
    pls  = o_rd_pulse;
    s_axi_rready = 1'b1;
    tick();
    s_axi_rready = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, output logic [1:0] rsp,
                          output logic [15:0] pls, output logic done);
    int  n = 0;
    bit  aw_done = 0, w_done = 0, aw_hs, w_hs;
    s_axi_awaddr  = addr;
    s_axi_awvalid = 1'b1;
    s_axi_wdata   = data;
    s_axi_wstrb   = strb;
    s_axi_wvalid  = 1'b1;
    while (!(aw_done && w_done) && n < 20) begin
      aw_hs = s_axi_awvalid && s_axi_awready;
      w_hs  = s_axi_wvalid && s_axi_wready;
      tick();
      if (aw_hs) begin aw_done = 1; s_axi_awvalid = 1'b0; end
      if (w_hs)  begin w_done = 1;  s_axi_wvalid = 1'b0;  end
      n++;
    end
    s_axi_awvalid = 1'b0;
    s_axi_wvalid  = 1'b0;
    done = aw_done && w_done && s_axi_bvalid;
    rsp  = s_axi_bresp;
    pls  = o_wr_pulse;
    s_axi_bready = 1'b1;
    tick();
    s_axi_bready = 1'b0;
  endtask

  initial begin
    i_rstn = 1'b0;
    s_axi_araddr = '0; s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;
    s_axi_awaddr = '0; s_axi_awvalid = 1'b0;
    s_axi_wdata = '0;  s_axi_wstrb = '0; s_axi_wvalid = 1'b0; s_axi_bready = 1'b0;
    i_ro_val = '0;
    i_ro_val[32*2 +: 32] = 32'h12345678;
    i_ro_val[32*1 +: 32] = 32'hCAFEF00D;
    for (int i = 0; i < 16; i++) model[i] = '0;

    tick(); tick();
    check_output("rst_arready", s_axi_arready, 1'b1);
    check_output("rst_valids", {s_axi_rvalid, s_axi_bvalid, s_axi_awready, s_axi_wready}, 4'b0000);
    check_output("rst_resp_data", {s_axi_rdata, s_axi_rresp, s_axi_bresp}, 36'h0);
    check_output("rst_regs", o_reg_q, 512'h0);
    check_output("rst_pulses", {o_wr_pulse, o_rd_pulse}, 32'h0);
    i_rstn = 1'b1;
    tick();

    $display("[TB] read reg3 after reset");
    do_read(32'h0C, rdata, resp, pulse, ok);
    check_output("rd3_latency", ok, 1'b1);
    check_output("rd3_data", rdata, 32'h0);
    check_output("rd3_resp", resp, 2'b00);
    check_output("rd3_pulse", pulse, 16'h0008);

    $display("[TB] full and partial strobe writes to reg1");
    do_write(32'h04, 32'hDEADBEEF, 4'hF, resp, pulse, ok);
    check_output("wr1_done", ok, 1'b1);
    check_output("wr1_resp", resp, 2'b00);
    check_output("wr1_pulse", pulse, 16'h0002);
    check_output("wr1_reg", o_reg_q[63:32], 32'hDEADBEEF);
    do_write(32'h04, 32'h00001122, 4'h3, resp, pulse, ok);
    check_output("wr1b_resp", {ok, resp}, 3'b100);
    check_output("wr1b_reg", o_reg_q[63:32], 32'hDEAD1122);
    model[1] = 32'hDEAD1122;
    do_read(32'h07, rdata, resp, pulse, ok);
    check_output("rd1_low_bits_ignored", {ok, rdata, resp, pulse}, {1'b1, 32'hDEAD1122, 2'b00, 16'h0002});

    $display("[TB] W leads AW by three cycles, bready held low");
    cnt_before = wr_cnt;
    s_axi_wdata = 32'hA5A50F0F; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
    tick();
    check_output("skew_wready", {s_axi_wready, s_axi_awready}, 2'b11);
    tick();
    s_axi_wvalid = 1'b0;
    tick(); tick();
    check_output("skew_wait_ready", {s_axi_wready, s_axi_awready, s_axi_bvalid}, 3'b010);
    s_axi_awaddr = 32'h14; s_axi_awvalid = 1'b1;
    tick();
    s_axi_awvalid = 1'b0;
    check_output("skew_pulse", o_wr_pulse, 16'h0020);
    held = 0;
    for (int i = 0; i < 5; i++) begin
      if (s_axi_bvalid === 1'b1 && s_axi_bresp === 2'b00) held++;
      tick();
    end
    check_output("skew_bvalid_held", held, 5);
    s_axi_bready = 1'b1;
    tick();
    s_axi_bready = 1'b0;
    check_output("skew_bvalid_dropped", s_axi_bvalid, 1'b0);
    check_output("skew_single_pulse", wr_cnt - cnt_before, 1);
    model[5] = 32'hA5A50F0F;
    check_output("skew_regs", o_reg_q, packed_model());

    $display("[TB] read-only register 2");
    do_read(32'h08, rdata, resp, pulse, ok);
    check_output("ro_read", {ok, rdata, resp, pulse}, {1'b1, 32'h12345678, 2'b00, 16'h0004});
    do_write(32'h08, 32'hFFFFFFFF, 4'hF, resp, pulse, ok);
    check_output("ro_write_resp", {ok, resp, pulse}, {1'b1, 2'b10, 16'h0000});
    check_output("ro_write_regs", o_reg_q, packed_model());

    $display("[TB] out-of-range address 0x40");
    cnt_before = rd_cnt;
    do_read(32'h40, rdata, resp, pulse, ok);
    check_output("oor_read", {ok, rdata, resp, pulse}, {1'b1, 32'h0, 2'b11, 16'h0000});
    check_output("oor_read_pulses", rd_cnt - cnt_before, 0);
    cnt_before = wr_cnt;
    do_write(32'h40, 32'h55AA55AA, 4'hF, resp, pulse, ok);
    check_output("oor_write_resp", {ok, resp}, 3'b111);
    check_output("oor_write_pulses", wr_cnt - cnt_before, 0);
    check_output("oor_write_regs", o_reg_q, packed_model());

    $display("[TB] zero strobe write to reg3");
    do_write(32'h0C, 32'hFFFFFFFF, 4'h0, resp, pulse, ok);
    check_output("zstrb", {ok, resp, pulse}, {1'b1, 2'b00, 16'h0008});
    check_output("zstrb_regs", o_reg_q, packed_model());

    $display("[TB] simultaneous read and write, then reset during response");
    s_axi_araddr = 32'h04; s_axi_arvalid = 1'b1;
    s_axi_awaddr = 32'h10; s_axi_awvalid = 1'b1;
    s_axi_wdata = 32'h0BADF00D; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
    tick();
    s_axi_arvalid = 1'b0;
    check_output("arb_read_first", {s_axi_rvalid, s_axi_awready, s_axi_wready}, 3'b100);
    check_output("arb_rdata", {s_axi_rdata, s_axi_rresp}, {32'hDEAD1122, 2'b00});
    s_axi_rready = 1'b1;
    tick();
    s_axi_rready = 1'b0;
    check_output("arb_back_idle", {s_axi_arready, s_axi_rvalid}, 2'b10);
    tick();
    check_output("arb_wr_acc", {s_axi_awready, s_axi_wready}, 2'b11);
    tick();
    s_axi_awvalid = 1'b0;
    s_axi_wvalid  = 1'b0;
    check_output("arb_write_resp", {s_axi_bvalid, s_axi_bresp, o_wr_pulse}, {1'b1, 2'b00, 16'h0010});
    check_output("arb_reg4", o_reg_q[159:128], 32'h0BADF00D);
    i_rstn = 1'b0;
    tick();
    check_output("midrst_bvalid", s_axi_bvalid, 1'b0);
    check_output("midrst_regs", o_reg_q, 512'h0);
    i_rstn = 1'b1;
    tick();
    check_output("midrst_no_resp", {s_axi_bvalid, s_axi_arready}, 2'b01);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
